// File: rtl/demux_memoria1x4_4bits_if.sv
// Serialized 4-bit stream in, four registered lanes out.
// The master drives the stream; the slave is the demux.
interface demux_memoria1x4_4bits_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] data_in;
  logic             valid_input;
  logic             realign;
  logic [WIDTH-1:0] data_out0;
  logic [WIDTH-1:0] data_out1;
  logic [WIDTH-1:0] data_out2;
  logic [WIDTH-1:0] data_out3;
  logic             valid_out0;
  logic             valid_out1;
  logic             valid_out2;
  logic             valid_out3;
  logic [1:0]       lane_ptr;
  logic             frame_done;

  modport master (
    output data_in, valid_input, realign,
    input  data_out0, data_out1, data_out2, data_out3,
    input  valid_out0, valid_out1, valid_out2, valid_out3,
    input  lane_ptr, frame_done
  );

  modport slave (
    input  data_in, valid_input, realign,
    output data_out0, data_out1, data_out2, data_out3,
    output valid_out0, valid_out1, valid_out2, valid_out3,
    output lane_ptr, frame_done
  );
endinterface

// File: rtl/demux_memoria1x4_4bits.sv
// 1x4 demux with memory: spreads valid words round-robin
// over four held lanes, pulsing frame_done after lane 3.
module demux_memoria1x4_4bits #(
  parameter int WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_L,
  demux_memoria1x4_4bits_if.slave      bus
);
  logic [WIDTH-1:0] data_q [4];
  logic [3:0]       vld_q;
  logic [1:0]       ptr_q;
  logic             frame_q;
  logic [1:0]       eff;

  // realign restarts at lane 0 in the same edge it is seen
  assign eff = bus.realign ? 2'd0 : ptr_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
      vld_q   <= '0;
      ptr_q   <= 2'd0;
      frame_q <= 1'b0;
    end else begin
      vld_q   <= '0;
      frame_q <= 1'b0;
      if (bus.valid_input) begin
        data_q[eff] <= bus.data_in;
        vld_q[eff]  <= 1'b1;
        ptr_q       <= eff + 2'd1;
        frame_q     <= (eff == 2'd3);
      end else if (bus.realign) begin
        ptr_q <= 2'd0;
      end
    end
  end

  assign bus.data_out0  = data_q[0];
  assign bus.data_out1  = data_q[1];
  assign bus.data_out2  = data_q[2];
  assign bus.data_out3  = data_q[3];
  assign bus.valid_out0 = vld_q[0];
  assign bus.valid_out1 = vld_q[1];
  assign bus.valid_out2 = vld_q[2];
  assign bus.valid_out3 = vld_q[3];
  assign bus.lane_ptr   = ptr_q;
  assign bus.frame_done = frame_q;
endmodule

// File: tb/tb_demux_memoria1x4_4bits.sv
// Bench for demux_memoria1x4_4bits: lane model checked every
// cycle plus literal expectations for each scenario.
module tb_demux_memoria1x4_4bits;
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  int   tests = 0;
  int   failed = 0;

  demux_memoria1x4_4bits_if #(.WIDTH(4)) bus ();

  demux_memoria1x4_4bits #(.WIDTH(4)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [3:0] dout [4];
  logic [3:0] vout;
  assign dout[0] = bus.data_out0;
  assign dout[1] = bus.data_out1;
  assign dout[2] = bus.data_out2;
  assign dout[3] = bus.data_out3;
  assign vout = {bus.valid_out3, bus.valid_out2,
                 bus.valid_out1, bus.valid_out0};

  // Model: which lane holds what, which lane just got a word.
  logic [3:0] m_data [4];
  logic [3:0] m_vld;
  int         m_ptr;
  logic       m_frame;

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_data[i] = 4'h0;
    m_vld   = 4'h0;
    m_ptr   = 0;
    m_frame = 1'b0;
  endtask

  task automatic step(input logic v, input logic [3:0] d,
                      input logic r);
    int lane;
    bus.valid_input = v;
    bus.data_in     = d;
    bus.realign     = r;
    @(posedge clk);
    m_vld   = 4'h0;
    m_frame = 1'b0;
    if (v) begin
      lane         = r ? 0 : m_ptr;
      m_data[lane] = d;
      m_vld[lane]  = 1'b1;
      m_frame      = (lane == 3);
      m_ptr        = (lane + 1) % 4;
    end else if (r) begin
      m_ptr = 0;
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      chk($sformatf("model data_out%0d", i), 8'(dout[i]), 8'(m_data[i]));
    chk("model valid_out", 8'(vout), 8'(m_vld));
    chk("model lane_ptr", 8'(bus.lane_ptr), 8'(m_ptr));
    chk("model frame_done", 8'(bus.frame_done), 8'(m_frame));
  end

  initial begin
    model_reset();
    bus.valid_input = 1'b1;
    bus.data_in     = 4'hF;
    bus.realign     = 1'b0;
    // Reset held across edges with a valid word present
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst data_out0", 8'(dout[0]), 8'h0);
    chk("rst data_out3", 8'(dout[3]), 8'h0);
    chk("rst valid_out", 8'(vout), 8'h0);
    chk("rst lane_ptr", 8'(bus.lane_ptr), 8'h0);
    chk("rst frame_done", 8'(bus.frame_done), 8'h0);
    bus.valid_input = 1'b0;
    reset_L = 1'b1;
    @(negedge clk);

    // Full frame
    step(1, 4'hA, 0);
    chk("frame v0", 8'(vout), 8'h1);
    step(1, 4'hB, 0);
    chk("frame v1", 8'(vout), 8'h2);
    step(1, 4'hC, 0);
    step(1, 4'hD, 0);
    chk("frame v3", 8'(vout), 8'h8);
    chk("frame done", 8'(bus.frame_done), 8'h1);
    chk("frame ptr", 8'(bus.lane_ptr), 8'h0);
    chk("frame d0", 8'(dout[0]), 8'hA);
    chk("frame d1", 8'(dout[1]), 8'hB);
    chk("frame d2", 8'(dout[2]), 8'hC);
    chk("frame d3", 8'(dout[3]), 8'hD);

    // Gaps and memory
    step(1, 4'h1, 0);
    step(0, 4'h7, 0);
    chk("gap valid", 8'(vout), 8'h0);
    chk("gap ptr", 8'(bus.lane_ptr), 8'h1);
    step(0, 4'h7, 0);
    chk("gap d0 held", 8'(dout[0]), 8'h1);
    step(1, 4'h2, 0);
    chk("gap d1", 8'(dout[1]), 8'h2);
    chk("gap v1", 8'(vout), 8'h2);

    // Realign alone from lane 2
    step(0, 4'h7, 1);
    chk("realign idle ptr", 8'(bus.lane_ptr), 8'h0);
    chk("realign idle valid", 8'(vout), 8'h0);

    // Wrap through six words
    for (int i = 1; i <= 6; i++) begin
      step(1, 4'(i), 0);
      chk($sformatf("wrap frame %0d", i),
          8'(bus.frame_done), (i == 4) ? 8'h1 : 8'h0);
    end
    chk("wrap d0", 8'(dout[0]), 8'h5);
    chk("wrap d1", 8'(dout[1]), 8'h6);
    chk("wrap d2", 8'(dout[2]), 8'h3);
    chk("wrap d3", 8'(dout[3]), 8'h4);

    // Realign with a valid word
    step(0, 4'h0, 1);
    step(1, 4'h3, 0);
    step(1, 4'h4, 0);
    chk("pre-realign ptr", 8'(bus.lane_ptr), 8'h2);
    step(1, 4'h9, 1);
    chk("realign d0", 8'(dout[0]), 8'h9);
    chk("realign v0", 8'(vout), 8'h1);
    chk("realign ptr", 8'(bus.lane_ptr), 8'h1);
    chk("realign d1 held", 8'(dout[1]), 8'h4);

    // Async reset mid-frame, asserted between edges
    step(1, 4'hA, 0);
    step(1, 4'hB, 0);
    bus.valid_input = 1'b0;
    #2;
    reset_L = 1'b0;
    model_reset();
    #1;
    chk("async d0", 8'(dout[0]), 8'h0);
    chk("async d1", 8'(dout[1]), 8'h0);
    chk("async ptr", 8'(bus.lane_ptr), 8'h0);
    chk("async valid", 8'(vout), 8'h0);
    @(negedge clk);
    reset_L = 1'b1;
    step(1, 4'hC, 0);
    chk("post-rst d0", 8'(dout[0]), 8'hC);
    chk("post-rst v0", 8'(vout), 8'h1);
    chk("post-rst ptr", 8'(bus.lane_ptr), 8'h1);
    chk("post-rst d1", 8'(dout[1]), 8'h0);
    step(0, 4'h0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
